// File: rtl/uart_rx_packet_ctrl.sv
// Packet framer behind a UART receiver: parses SYNC/ADDR/LEN/PAYLOAD/CSUM frames,
// verifies the XOR checksum and replays the buffered payload as register writes.
`timescale 1ns/1ps
module uart_rx_packet_ctrl #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int                GAP_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0]  GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_LEN   = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_CSUM  = 3'd4;
    localparam logic [2:0] ST_WRITE = 3'd5;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CSUM = 2'b01;
    localparam logic [1:0] ERR_TOUT = 2'b10;
    localparam logic [1:0] ERR_LEN  = 2'b11;

    logic [2:0]       r_state, r_state_next;
    logic             r_rx_valid_q;
    logic [7:0]       r_base, r_base_next;
    logic [3:0]       r_len, r_len_next;
    logic [3:0]       r_idx, r_idx_next;
    logic [7:0]       r_xor, r_xor_next;
    logic [GAP_W-1:0] r_gap, r_gap_next;
    logic             r_wr_en, r_wr_en_next;
    logic [7:0]       r_wr_addr, r_wr_addr_next;
    logic [7:0]       r_wr_data, r_wr_data_next;
    logic             r_pkt_ok, r_pkt_ok_next;
    logic             r_pkt_err, r_pkt_err_next;
    logic [1:0]       r_err_code, r_err_code_next;
    logic             r_busy;
    logic [7:0]       r_buf [16];

    logic             w_accept;
    logic             w_active;
    logic             w_buf_we;
    logic [GAP_W-1:0] w_gap_inc;
    logic [3:0]       w_rd_idx;
    logic [7:0]       w_rd_data;

    // Only a rising edge of the receiver's level delivers a new byte.
    assign w_accept  = rx_valid & ~r_rx_valid_q;
    assign w_active  = (r_state == ST_ADDR) || (r_state == ST_LEN) ||
                       (r_state == ST_DATA) || (r_state == ST_CSUM);
    assign w_gap_inc = r_gap + GAP_W'(1);
    assign w_rd_idx  = (r_state == ST_WRITE) ? r_idx : 4'd0;
    assign w_rd_data = r_buf[w_rd_idx];

    always_comb begin
        r_state_next    = r_state;
        r_base_next     = r_base;
        r_len_next      = r_len;
        r_idx_next      = r_idx;
        r_xor_next      = r_xor;
        r_gap_next      = r_gap;
        r_wr_en_next    = 1'b0;
        r_wr_addr_next  = r_wr_addr;
        r_wr_data_next  = r_wr_data;
        r_pkt_ok_next   = 1'b0;
        r_pkt_err_next  = 1'b0;
        r_err_code_next = r_err_code;
        w_buf_we        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                r_gap_next = '0;
                r_xor_next = 8'd0;
                if (w_accept && rx_data == SYNC_BYTE) begin
                    r_state_next = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (w_accept) begin
                    r_base_next  = rx_data;
                    r_xor_next   = rx_data;
                    r_state_next = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_accept) begin
                    if (rx_data[7:4] != 4'd0) begin
                        r_pkt_err_next  = 1'b1;
                        r_err_code_next = ERR_LEN;
                        r_state_next    = ST_IDLE;
                    end else begin
                        r_len_next   = rx_data[3:0];
                        r_xor_next   = r_xor ^ rx_data;
                        r_idx_next   = 4'd0;
                        r_state_next = (rx_data[3:0] == 4'd0) ? ST_CSUM : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_accept) begin
                    w_buf_we   = 1'b1;
                    r_xor_next = r_xor ^ rx_data;
                    if (r_idx == r_len - 4'd1) begin
                        r_state_next = ST_CSUM;
                    end else begin
                        r_idx_next = r_idx + 4'd1;
                    end
                end
            end
            ST_CSUM: begin
                if (w_accept) begin
                    if (rx_data != r_xor) begin
                        r_pkt_err_next  = 1'b1;
                        r_err_code_next = ERR_CSUM;
                        r_state_next    = ST_IDLE;
                    end else if (r_len == 4'd0) begin
                        r_pkt_ok_next   = 1'b1;
                        r_err_code_next = ERR_NONE;
                        r_state_next    = ST_IDLE;
                    end else begin
                        // First write goes out in the cycle right after the checksum.
                        r_wr_en_next   = 1'b1;
                        r_wr_addr_next = r_base;
                        r_wr_data_next = w_rd_data;
                        r_idx_next     = 4'd1;
                        r_state_next   = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (r_idx == r_len) begin
                    r_pkt_ok_next   = 1'b1;
                    r_err_code_next = ERR_NONE;
                    r_state_next    = ST_IDLE;
                end else begin
                    r_wr_en_next   = 1'b1;
                    r_wr_addr_next = r_base + {4'd0, r_idx};
                    r_wr_data_next = w_rd_data;
                    r_idx_next     = r_idx + 4'd1;
                end
            end
            default: begin
                r_state_next = ST_IDLE;
            end
        endcase

        // An accepted byte always beats the timeout in the same cycle.
        if (w_active) begin
            if (w_accept) begin
                r_gap_next = '0;
            end else if (w_gap_inc == GAP_LIMIT) begin
                r_gap_next      = '0;
                r_pkt_err_next  = 1'b1;
                r_err_code_next = ERR_TOUT;
                r_state_next    = ST_IDLE;
            end else begin
                r_gap_next = w_gap_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_rx_valid_q <= 1'b1;
            r_base       <= 8'd0;
            r_len        <= 4'd0;
            r_idx        <= 4'd0;
            r_xor        <= 8'd0;
            r_gap        <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= 8'd0;
            r_wr_data    <= 8'd0;
            r_pkt_ok     <= 1'b0;
            r_pkt_err    <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= r_state_next;
            r_rx_valid_q <= rx_valid;
            r_base       <= r_base_next;
            r_len        <= r_len_next;
            r_idx        <= r_idx_next;
            r_xor        <= r_xor_next;
            r_gap        <= r_gap_next;
            r_wr_en      <= r_wr_en_next;
            r_wr_addr    <= r_wr_addr_next;
            r_wr_data    <= r_wr_data_next;
            r_pkt_ok     <= r_pkt_ok_next;
            r_pkt_err    <= r_pkt_err_next;
            r_err_code   <= r_err_code_next;
            r_busy       <= (r_state_next != ST_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            r_buf[r_idx] <= rx_data;
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign pkt_ok   = r_pkt_ok;
    assign pkt_err  = r_pkt_err;
    assign err_code = r_err_code;
    assign busy     = r_busy;

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Directed bench for uart_rx_packet_ctrl: packet table plus timeout, gap-63 and mid-write reset sequences.
`timescale 1ns/1ps
module tb_uart_rx_packet_ctrl;

    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       pkt_ok;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       busy;

    uart_rx_packet_ctrl #(
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .pkt_ok  (pkt_ok),
        .pkt_err (pkt_err),
        .err_code(err_code),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int               nb;
        logic [0:19][7:0] b;
        int               nw;
        logic [0:15][7:0] wa;
        logic [0:15][7:0] wd;
        int               ok;
        int               err;
        logic [1:0]       code;
    } vec_t;

    vec_t vecs [6];

    int checks = 0;
    int errors = 0;

    // Event monitor, sampled on the falling edge.
    int         cyc = 0;
    int         m_nw = 0;
    int         m_ok = 0;
    int         m_err = 0;
    int         m_okcyc = 0;
    int         m_both = 0;
    logic [7:0] m_wa [64];
    logic [7:0] m_wd [64];
    int         m_wc [64];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (wr_en) begin
            if (m_nw < 64) begin
                m_wa[m_nw] <= wr_addr;
                m_wd[m_nw] <= wr_data;
                m_wc[m_nw] <= cyc;
            end
            m_nw <= m_nw + 1;
        end
        if (pkt_ok) begin
            m_ok    <= m_ok + 1;
            m_okcyc <= cyc;
        end
        if (pkt_err) m_err <= m_err + 1;
        if (pkt_ok && pkt_err) m_both <= m_both + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_nw, s_ok, s_err, found, nwr;

        vecs[0] = '0;
        vecs[0].nb = 6;  vecs[0].b  = {8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21, {14{8'h00}}};
        vecs[0].nw = 2;  vecs[0].wa = {8'h10, 8'h11, {14{8'h00}}};
        vecs[0].wd = {8'h11, 8'h22, {14{8'h00}}};
        vecs[0].ok = 1;  vecs[0].err = 0; vecs[0].code = 2'b00;

        vecs[1] = '0;
        vecs[1].nb = 6;  vecs[1].b  = {8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20, {14{8'h00}}};
        vecs[1].nw = 0;  vecs[1].ok = 0; vecs[1].err = 1; vecs[1].code = 2'b01;

        vecs[2] = '0;
        vecs[2].nb = 6;  vecs[2].b  = {8'hA5, 8'h10, 8'h20, 8'h11, 8'h22, 8'h33, {14{8'h00}}};
        vecs[2].nw = 0;  vecs[2].ok = 0; vecs[2].err = 1; vecs[2].code = 2'b11;

        vecs[3] = '0;
        vecs[3].nb = 6;  vecs[3].b  = {8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'hEC, {14{8'h00}}};
        vecs[3].nw = 2;  vecs[3].wa = {8'hFF, 8'h00, {14{8'h00}}};
        vecs[3].wd = {8'hAA, 8'hBB, {14{8'h00}}};
        vecs[3].ok = 1;  vecs[3].err = 0; vecs[3].code = 2'b00;

        vecs[4] = '0;
        vecs[4].nb = 6;  vecs[4].b  = {8'h00, 8'h3C, 8'hA5, 8'h00, 8'h00, 8'h00, {14{8'h00}}};
        vecs[4].nw = 0;  vecs[4].ok = 1; vecs[4].err = 0; vecs[4].code = 2'b00;

        // LEN=15 at base 0x20 with payload 01..0F; XOR of 01..0F is 0 so CSUM=20^0F=2F.
        // A trailing A5 lands during WRITE and must not open a new packet.
        vecs[5] = '0;
        vecs[5].nb = 20; vecs[5].nw = 15; vecs[5].ok = 1; vecs[5].err = 0; vecs[5].code = 2'b00;
        vecs[5].b[0] = 8'hA5; vecs[5].b[1] = 8'h20; vecs[5].b[2] = 8'h0F;
        for (int i = 0; i < 15; i++) begin
            vecs[5].b[3+i] = 8'(i + 1);
            vecs[5].wa[i]  = 8'(8'h20 + i);
            vecs[5].wd[i]  = 8'(i + 1);
        end
        vecs[5].b[18] = 8'h2F; vecs[5].b[19] = 8'hA5;

        // Reset state, with rx_valid already high across release.
        reset    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {24'd0, wr_data}, 32'd0);
        check("rst_pkt_ok", {31'd0, pkt_ok}, 32'd0);
        check("rst_pkt_err", {31'd0, pkt_err}, 32'd0);
        check("rst_err_code", {30'd0, err_code}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("held_valid_not_consumed_busy", {31'd0, busy}, 32'd0);
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 6; v++) begin
            s_nw = m_nw; s_ok = m_ok; s_err = m_err;
            for (int i = 0; i < vecs[v].nb; i++) send_byte(vecs[v].b[i]);
            repeat (24) @(posedge clk);
            @(negedge clk);
            #1;
            nwr = m_nw - s_nw;
            check($sformatf("vec%0d_nwrites", v), nwr, vecs[v].nw);
            for (int i = 0; i < vecs[v].nw && i < nwr; i++) begin
                check($sformatf("vec%0d_wr%0d_addr", v, i), {24'd0, m_wa[s_nw+i]}, {24'd0, vecs[v].wa[i]});
                check($sformatf("vec%0d_wr%0d_data", v, i), {24'd0, m_wd[s_nw+i]}, {24'd0, vecs[v].wd[i]});
                check($sformatf("vec%0d_wr%0d_cycle", v, i), m_wc[s_nw+i] - m_wc[s_nw], i);
            end
            check($sformatf("vec%0d_pkt_ok_count", v), m_ok - s_ok, vecs[v].ok);
            check($sformatf("vec%0d_pkt_err_count", v), m_err - s_err, vecs[v].err);
            check($sformatf("vec%0d_err_code", v), {30'd0, err_code}, {30'd0, vecs[v].code});
            check($sformatf("vec%0d_busy_after", v), {31'd0, busy}, 32'd0);
            if (vecs[v].ok == 1 && vecs[v].nw > 0 && nwr == vecs[v].nw) begin
                check($sformatf("vec%0d_ok_after_last_wr", v), m_okcyc - m_wc[s_nw+nwr-1], 1);
            end
        end

        // Timeout: pkt_err appears 64 edges after the last accepted byte.
        s_err = m_err;
        send_byte(8'hA5);
        send_byte(8'h10);
        found = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (pkt_err) begin
                found = k;
                break;
            end
        end
        check("timeout_cycle", found, TO);
        check("timeout_err_code", {30'd0, err_code}, 32'd2);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        check("timeout_err_pulse_len", m_err - s_err, 1);

        // Byte accepted with the gap counter at 63 must not time out.
        s_ok = m_ok; s_err = m_err;
        send_byte(8'hA5);
        send_byte(8'h10);
        repeat (TO - 1) @(posedge clk);
        send_byte(8'h00);
        send_byte(8'h10);
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        check("gap63_no_err", m_err - s_err, 0);
        check("gap63_pkt_ok", m_ok - s_ok, 1);
        check("gap63_err_code", {30'd0, err_code}, 32'd0);

        // Asynchronous reset in the middle of WRITE.
        send_byte(8'hA5);
        send_byte(8'h40);
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h43);
        check("midwr_first_wr_en", {31'd0, wr_en}, 32'd1);
        check("midwr_first_addr", {24'd0, wr_addr}, 32'h40);
        #2;
        reset = 1'b0;
        #1;
        check("midwr_rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("midwr_rst_busy", {31'd0, busy}, 32'd0);
        check("midwr_rst_wr_addr", {24'd0, wr_addr}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        s_nw = m_nw; s_ok = m_ok; s_err = m_err;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        check("midwr_no_more_writes", m_nw - s_nw, 0);
        check("midwr_no_pkt_ok", m_ok - s_ok, 0);
        check("midwr_no_pkt_err", m_err - s_err, 0);
        check("midwr_err_code", {30'd0, err_code}, 32'd0);

        check("no_ok_err_overlap", m_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
